fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the rv32i pipeline. It compares NUM_SRC decode-stage source registers against NUM_STAGES in-flight producer stages. It selects the youngest valid producer per source and raises a stall when the youngest match's data is not yet available (load in flight). A small FSM tracks stall duration, enforces a watchdog, and honours pipeline flush.

---
 rtl/fwd_hazard_unit_if.sv | 43 ++++
 rtl/fwd_hazard_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit_if
// Brief    : Decode/producer-stage bundle for the forwarding and hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
interface fwd_hazard_unit_if #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3
);
  localparam int SW = $clog2(NUM_STAGES);

  logic                         flush;
  logic [NUM_SRC*REG_AW-1:0]    src_addr;
  logic [NUM_SRC-1:0]           src_used;
  logic [NUM_STAGES-1:0]        stg_wen;
  logic [NUM_STAGES*REG_AW-1:0] stg_rd;
  logic [NUM_STAGES*XLEN-1:0]   stg_data;
  logic [NUM_STAGES-1:0]        stg_data_vld;
  logic [NUM_SRC-1:0]           fwd_hit;
  logic [NUM_SRC*XLEN-1:0]      fwd_val;
  logic [NUM_SRC*SW-1:0]        fwd_stage;
  logic                         stall;
  logic [7:0]                   stall_cnt;
  logic                         stall_timeout;
  logic [31:0]                  stat_fwd;
  logic [31:0]                  stat_stall;

  modport master (
    output flush, src_addr, src_used, stg_wen, stg_rd, stg_data, stg_data_vld,
    input  fwd_hit, fwd_val, fwd_stage, stall, stall_cnt, stall_timeout,
           stat_fwd, stat_stall
  );

  modport slave (
    input  flush, src_addr, src_used, stg_wen, stg_rd, stg_data, stg_data_vld,
    output fwd_hit, fwd_val, fwd_stage, stall, stall_cnt, stall_timeout,
           stat_fwd, stat_stall
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : Youngest-producer operand forwarding with load-use stall FSM,
//            stall watchdog and optional event counters (macro FWD_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int STALL_MAX  = 15
) (
  input  wire                 clk,
  input  wire                 rst,
  fwd_hazard_unit_if.slave    bus
);
  localparam int SW = $clog2(NUM_STAGES);
  localparam logic [7:0] c_stall_max = 8'(STALL_MAX);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

  logic [NUM_SRC-1:0] w_hit;
  logic [NUM_SRC-1:0] w_hazard;
  logic               w_stall;
  state_t             r_state, w_state_nxt;
  logic [7:0]         r_stall_cnt, w_cnt_nxt;
  logic               r_timeout;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_AW-1:0] w_addr;
    logic              w_found;
    logic              w_vld;
    logic [SW-1:0]     w_win;
    logic [XLEN-1:0]   w_val;

    assign w_addr = bus.src_addr[s*REG_AW +: REG_AW];

    // Scan oldest to youngest so the youngest match overrides older ones.
    always_comb begin
      w_found = 1'b0;
      w_vld   = 1'b0;
      w_win   = '0;
      w_val   = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (bus.stg_wen[i] && (bus.stg_rd[i*REG_AW +: REG_AW] == w_addr) &&
            (w_addr != '0) && bus.src_used[s]) begin
          w_found = 1'b1;
          w_vld   = bus.stg_data_vld[i];
          w_win   = SW'(i);
          w_val   = bus.stg_data[i*XLEN +: XLEN];
        end
      end
    end

    assign w_hit[s]    = w_found && w_vld;
    assign w_hazard[s] = w_found && !w_vld;
    assign bus.fwd_val[s*XLEN +: XLEN] = w_hit[s] ? w_val : '0;
    assign bus.fwd_stage[s*SW +: SW]   = w_hit[s] ? w_win : '0;
  end : g_src

  assign w_stall     = (|w_hazard) && !bus.flush && !rst;
  assign bus.fwd_hit = w_hit;
  assign bus.stall   = w_stall;

  // Flush is already folded into w_stall, so dropping stall covers it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_stall_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_stall) begin
          w_state_nxt = S_STALL;
          w_cnt_nxt   = 8'd1;
        end else begin
          w_cnt_nxt   = 8'd0;
        end
      end
      S_STALL: begin
        if (w_stall) begin
          w_cnt_nxt   = (r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_cnt_nxt;
      if (w_stall && (w_cnt_nxt >= c_stall_max)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.stall_timeout = r_timeout;

`ifdef FWD_STATS_EN
  logic [31:0] r_stat_fwd, r_stat_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_fwd   <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if ((|w_hit) && (r_stat_fwd != 32'hFFFF_FFFF)) begin
        r_stat_fwd <= r_stat_fwd + 32'd1;
      end
      if (w_stall && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign bus.stat_fwd   = r_stat_fwd;
  assign bus.stat_stall = r_stat_stall;
`else
  assign bus.stat_fwd   = 32'd0;
  assign bus.stat_stall = 32'd0;
`endif

endmodule
`default_nettype wire
